// File: rtl/seq_detect_ctrl_if.sv
// Host-side bundle for the serial pattern detector run controller:
// configuration, run handshake and match reporting.
interface seq_detect_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
);
    localparam int IDX_W = $clog2(WORD_W);

    logic              cfg_we;
    logic [3:0]        cfg_pattern;
    logic              cfg_overlap;
    logic              start;
    logic [WORD_W-1:0] din;
    logic              busy;
    logic              done;
    logic              match_pulse;
    logic [IDX_W-1:0]  match_idx;
    logic [CNT_W-1:0]  match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, start, din,
        input  busy, done, match_pulse, match_idx, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, start, din,
        output busy, done, match_pulse, match_idx, match_cnt
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller: shifts a word MSB-first through a programmable 4-bit
// Mealy detector and reports match indices and a saturating count.
module seq_detect_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic rst_n,
    seq_detect_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        pattern_q;
    logic              overlap_q;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [2:0]        hist;
    logic [1:0]        hist_cnt;
    logic [CNT_W-1:0]  match_cnt;
    logic [IDX_W-1:0]  match_idx;
    logic              match_pulse;
    logic              done;
    logic              bit_in;
    logic              hit;
    logic              last_bit;
    logic              accept;
    logic [1:0]        hist_cnt_inc;

    assign bit_in       = shreg[WORD_W-1];
    assign hit          = (hist_cnt == 2'd3) && ({hist, bit_in} == pattern_q);
    assign last_bit     = (bit_idx == IDX_W'(WORD_W - 1));
    assign accept       = (state == IDLE) && bus.start;
    assign hist_cnt_inc = (hist_cnt == 2'd3) ? 2'd3 : hist_cnt + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state == SHIFT);
        bus.done        = done;
        bus.match_pulse = match_pulse;
        bus.match_idx   = match_idx;
        bus.match_cnt   = match_cnt;
    end

    // A write coinciding with start lands before the first bit is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= 4'b1001;
            overlap_q <= 1'b0;
        end else if (state == IDLE && bus.cfg_we) begin
            pattern_q <= bus.cfg_pattern;
            overlap_q <= bus.cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_idx     <= '0;
            hist        <= '0;
            hist_cnt    <= '0;
            match_cnt   <= '0;
            match_idx   <= '0;
            match_pulse <= 1'b0;
            done        <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            done        <= 1'b0;
            if (accept) begin
                shreg     <= bus.din;
                bit_idx   <= '0;
                hist      <= '0;
                hist_cnt  <= '0;
                match_cnt <= '0;
                match_idx <= '0;
            end else if (state == SHIFT) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
                hist  <= {hist[1:0], bit_in};
                if (hit) begin
                    match_pulse <= 1'b1;
                    match_idx   <= bit_idx;
                    if (!(&match_cnt)) match_cnt <= match_cnt + 1'b1;
                    hist_cnt <= overlap_q ? hist_cnt_inc : 2'd0;
                end else begin
                    hist_cnt <= hist_cnt_inc;
                end
                if (last_bit) begin
                    done <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a window-search model predicts
// each match; a second instance with a 2-bit counter covers saturation.
module tb_seq_detect_ctrl;
    localparam int W  = 8;
    localparam int IW = $clog2(W);

    typedef struct {
        int idx;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [3:0] cur_pat = 4'b1001;
    logic       cur_ov = 1'b0;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.WORD_W(W), .CNT_W(8)) bus ();
    seq_detect_ctrl_if #(.WORD_W(W), .CNT_W(2)) sbus ();

    seq_detect_ctrl #(.WORD_W(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    seq_detect_ctrl #(.WORD_W(W), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
    );

    // Slide a 4-bit window over the word (bit 0 = MSB); a non-overlapping
    // match may not reuse any bit of the previous match.
    function automatic int model(input logic [W-1:0] d, input logic [3:0] p,
                                 input logic ov, input int cmax);
        int last;
        int c;
        logic [3:0] win;
        last = -1;
        c = 0;
        for (int k = 3; k < W; k++) begin
            win = {d[W-1-(k-3)], d[W-1-(k-2)], d[W-1-(k-1)], d[W-1-k]};
            if (win == p && (ov || (k - 3) > last)) begin
                last = k;
                if (c < cmax) c++;
                q.push_back('{k, c});
            end
        end
        return c;
    endfunction

    task automatic run_word(input logic [W-1:0] d, input bit wcfg,
                            input logic [3:0] p, input logic ov,
                            input int inj_at, input int abort_at,
                            output int busy_n, output int done_at,
                            output int fin_cnt, output int cnt0);
        int n;
        exp_t e;
        if (wcfg) begin
            cur_pat = p;
            cur_ov = ov;
        end
        n = model(d, cur_pat, cur_ov, 255);
        bus.din = d;
        bus.start = 1'b1;
        bus.cfg_we = wcfg;
        bus.cfg_pattern = p;
        bus.cfg_overlap = ov;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.cfg_we = 1'b0;
        bus.din = '0;
        busy_n = 0;
        done_at = -1;
        fin_cnt = -1;
        cnt0 = -1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (i == inj_at + 1) begin
                bus.start = 1'b0;
                bus.cfg_we = 1'b0;
            end
            if (i == 0) cnt0 = int'(bus.match_cnt);
            if (bus.busy) busy_n++;
            if (bus.match_pulse) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected idx=%0d cnt=%0d",
                             bus.match_idx, bus.match_cnt);
                end else begin
                    e = q.pop_front();
                    if (bus.match_idx !== IW'(e.idx) ||
                        bus.match_cnt !== 8'(e.cnt)) begin
                        errors++;
                        $display("FAIL sb_match got idx=%0d cnt=%0d want idx=%0d cnt=%0d",
                                 bus.match_idx, bus.match_cnt, e.idx, e.cnt);
                    end
                end
            end
            if (bus.done) begin
                done_at = i;
                fin_cnt = int'(bus.match_cnt);
                break;
            end
            if (i == abort_at) break;
            if (i == inj_at) begin
                bus.start = 1'b1;
                bus.din = ~d;
                bus.cfg_we = 1'b1;
                bus.cfg_pattern = 4'b0000;
                bus.cfg_overlap = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_overlap = 0;
        bus.start = 0; bus.din = '0;
        sbus.cfg_we = 0; sbus.cfg_pattern = 0; sbus.cfg_overlap = 0;
        sbus.start = 0; sbus.din = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.match_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.busy, bus.done, bus.match_pulse});
        end
        checks++;
        if (bus.match_idx !== '0 || bus.match_cnt !== '0) begin
            errors++;
            $display("FAIL reset_match got idx=%0d cnt=%0d want 0 0",
                     bus.match_idx, bus.match_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_defaults();
        int b, d, f, c0;
        run_word(8'b1001_1001, 0, 4'h0, 0, -9, -9, b, d, f, c0);
        checks++;
        if (d !== W) begin errors++; $display("FAIL def_done_at got %0d want %0d", d, W); end
        checks++;
        if (b !== W) begin errors++; $display("FAIL def_busy got %0d want %0d", b, W); end
        checks++;
        if (f !== 2) begin errors++; $display("FAIL def_cnt got %0d want 2", f); end
        checks++;
        if (q.size() !== 0) begin errors++; $display("FAIL def_missed got %0d want 0", q.size()); end
        q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.match_idx !== 3'd7 || bus.match_cnt !== 8'd2 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL def_hold got idx=%0d cnt=%0d done=%b want 7 2 0",
                     bus.match_idx, bus.match_cnt, bus.done);
        end
    endtask

    task automatic test_overlap();
        int b, d, f, c0;
        run_word(8'b1001_0010, 1, 4'b1001, 1, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 2 || q.size() !== 0) begin
            errors++; $display("FAIL ovl_on got cnt=%0d left=%0d want 2 0", f, q.size());
        end
        q.delete();
        run_word(8'b1001_0010, 1, 4'b1001, 0, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 1 || q.size() !== 0) begin
            errors++; $display("FAIL ovl_off got cnt=%0d left=%0d want 1 0", f, q.size());
        end
        q.delete();
    endtask

    task automatic test_all_ones();
        int b, d, f, c0;
        run_word(8'hFF, 1, 4'b1111, 1, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 5 || q.size() !== 0) begin
            errors++; $display("FAIL ones_ovl got cnt=%0d left=%0d want 5 0", f, q.size());
        end
        q.delete();
        run_word(8'hFF, 1, 4'b1111, 0, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 2 || q.size() !== 0) begin
            errors++; $display("FAIL ones_novl got cnt=%0d left=%0d want 2 0", f, q.size());
        end
        q.delete();
    endtask

    task automatic test_back_to_back();
        int b, d, f, c0;
        run_word(8'b1001_1001, 1, 4'b1001, 0, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 2) begin errors++; $display("FAIL b2b_first got cnt=%0d want 2", f); end
        run_word(8'b0110_0000, 0, 4'h0, 0, -9, -9, b, d, f, c0);
        checks++;
        if (c0 !== 0) begin errors++; $display("FAIL b2b_clear got cnt=%0d want 0", c0); end
        checks++;
        if (d !== W || f !== 0) begin
            errors++; $display("FAIL b2b_second got done_at=%0d cnt=%0d want %0d 0", d, f, W);
        end
        q.delete();
    endtask

    task automatic test_ignored();
        int b, d, f, c0;
        run_word(8'b1001_1001, 0, 4'h0, 0, 2, -9, b, d, f, c0);
        checks++;
        if (d !== W || b !== W || f !== 2) begin
            errors++;
            $display("FAIL ign_run got done_at=%0d busy=%0d cnt=%0d want %0d %0d 2",
                     d, b, f, W, W);
        end
        q.delete();
        run_word(8'h00, 0, 4'h0, 0, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 0 || d !== W) begin
            errors++; $display("FAIL ign_cfg got cnt=%0d done_at=%0d want 0 %0d", f, d, W);
        end
        q.delete();
    endtask

    task automatic test_reset_midrun();
        int b, d, f, c0;
        bit seen_done;
        run_word(8'b1001_1001, 1, 4'b1001, 1, -9, 4, b, d, f, c0);
        checks++;
        if (bus.match_pulse !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got pulse=%b busy=%b want 1 1", bus.match_pulse, bus.busy);
        end
        q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.match_pulse} !== 3'b000 ||
            bus.match_idx !== '0 || bus.match_cnt !== '0) begin
            errors++;
            $display("FAIL mid_rst got busy=%b done=%b pulse=%b idx=%0d cnt=%0d want zeros",
                     bus.busy, bus.done, bus.match_pulse, bus.match_idx, bus.match_cnt);
        end
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
        end
        rst_n = 1'b1;
        cur_pat = 4'b1001;
        cur_ov = 1'b0;
        repeat (W) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL mid_no_done got activity=1 want 0"); end
        run_word(8'b1001_0010, 0, 4'h0, 0, -9, -9, b, d, f, c0);
        checks++;
        if (f !== 1 || q.size() !== 0) begin
            errors++; $display("FAIL mid_cfg_default got cnt=%0d want 1", f);
        end
        q.delete();
    endtask

    task automatic test_saturation();
        int exp_s[5] = '{1, 2, 3, 3, 3};
        int k;
        bit got_done;
        sbus.din = 8'hFF;
        sbus.start = 1'b1;
        sbus.cfg_we = 1'b1;
        sbus.cfg_pattern = 4'b1111;
        sbus.cfg_overlap = 1'b1;
        @(posedge clk);
        #1;
        sbus.start = 1'b0;
        sbus.cfg_we = 1'b0;
        k = 0;
        got_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (sbus.match_pulse) begin
                checks++;
                if (k >= 5 || sbus.match_cnt !== 2'(exp_s[k % 5])) begin
                    errors++;
                    $display("FAIL sat_step%0d got %0d want %0d", k, sbus.match_cnt,
                             exp_s[k % 5]);
                end
                k++;
            end
            if (sbus.done) begin
                got_done = 1;
                checks++;
                if (sbus.match_cnt !== 2'd3) begin
                    errors++; $display("FAIL sat_final got %0d want 3", sbus.match_cnt);
                end
                break;
            end
        end
        checks++;
        if (k !== 5 || !got_done) begin
            errors++; $display("FAIL sat_count got pulses=%0d done=%b want 5 1", k, got_done);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_overlap();
        test_all_ones();
        test_back_to_back();
        test_ignored();
        test_reset_midrun();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
